// File: rtl/reg_scoreboard_if.sv
// Bundles the ID read/issue, writeback and scoreboard status signals.
interface reg_scoreboard_if #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned PEND_W   = 2
);
  logic                       read1_flag;
  logic [ADDR_W-1:0]          read1_address;
  logic                       read2_flag;
  logic [ADDR_W-1:0]          read2_address;
  logic                       issue_valid;
  logic                       issue_wen;
  logic [ADDR_W-1:0]          issue_rd;
  logic                       flush;
  logic                       wb_flag;
  logic [ADDR_W-1:0]          wb_address;
  logic                       stall;
  logic                       issue_accept;
  logic [NUM_REGS-1:0]        busy_mask;
  logic [ADDR_W+PEND_W-1:0]   inflight_cnt;
  logic                       err_underflow;

  // Pipeline side: drives ID and writeback information, observes the verdict.
  modport master (
    output read1_flag, read1_address, read2_flag, read2_address,
           issue_valid, issue_wen, issue_rd, flush, wb_flag, wb_address,
    input  stall, issue_accept, busy_mask, inflight_cnt, err_underflow
  );

  // Scoreboard side.
  modport slave (
    input  read1_flag, read1_address, read2_flag, read2_address,
           issue_valid, issue_wen, issue_rd, flush, wb_flag, wb_address,
    output stall, issue_accept, busy_mask, inflight_cnt, err_underflow
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard: counts in-flight writes per register between ID issue and
// writeback, and stalls ID on RAW hazards the regfile writeback bypass cannot cover.
module reg_scoreboard #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned PEND_W   = 2
) (
  input logic              clk,
  input logic              rst,
  reg_scoreboard_if.slave  sb
);
  localparam int unsigned CNT_W    = ADDR_W + PEND_W;
  localparam int unsigned MAX_PEND = (1 << PEND_W) - 1;

  logic [PEND_W-1:0] pending_q [NUM_REGS];
  logic [PEND_W-1:0] pending_d [NUM_REGS];
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic              err_q, err_d;

  logic [PEND_W-1:0] pend_r1, pend_r2, pend_rd, pend_wb;
  logic              haz1, haz2, full;
  logic              stall_c, accept_c, inc, dec;
  logic [NUM_REGS-1:0] busy_c;

  // Hazard detection and issue decision, purely from inputs and current state.
  always_comb begin
    pend_r1  = pending_q[sb.read1_address];
    pend_r2  = pending_q[sb.read2_address];
    pend_rd  = pending_q[sb.issue_rd];
    pend_wb  = pending_q[sb.wb_address];

    // A single outstanding write retiring now is served by the regfile bypass.
    haz1 = sb.read1_flag && (sb.read1_address != '0) && (pend_r1 != '0) &&
           !(sb.wb_flag && (sb.wb_address == sb.read1_address) &&
             (pend_r1 == PEND_W'(1)));
    haz2 = sb.read2_flag && (sb.read2_address != '0) && (pend_r2 != '0) &&
           !(sb.wb_flag && (sb.wb_address == sb.read2_address) &&
             (pend_r2 == PEND_W'(1)));
    // A saturated counter may take one more issue only if it also retires one now.
    full = sb.issue_valid && sb.issue_wen && (sb.issue_rd != '0) &&
           (pend_rd == PEND_W'(MAX_PEND)) &&
           !(sb.wb_flag && (sb.wb_address == sb.issue_rd));

    stall_c  = !rst && sb.issue_valid && !sb.flush && (haz1 || haz2 || full);
    accept_c = !rst && sb.issue_valid && !sb.flush && !stall_c;
    inc      = accept_c && sb.issue_wen && (sb.issue_rd != '0);
    dec      = sb.wb_flag && (sb.wb_address != '0);
  end

  // Next-state for pending counters, in-flight total and sticky underflow flag.
  always_comb begin
    pending_d  = pending_q;
    inflight_d = inflight_q;
    err_d      = err_q;

    if (dec && (pend_wb == '0)) begin
      err_d = 1'b1;
    end

    if (inc && dec && (sb.issue_rd == sb.wb_address)) begin
      // Issue and retire on the same register cancel out.
    end else begin
      if (inc) begin
        pending_d[sb.issue_rd] = pend_rd + PEND_W'(1);
        inflight_d             = inflight_d + CNT_W'(1);
      end
      if (dec && (pend_wb != '0)) begin
        pending_d[sb.wb_address] = pend_wb - PEND_W'(1);
        inflight_d               = inflight_d - CNT_W'(1);
      end
    end
    pending_d[0] = '0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < int'(NUM_REGS); r++) begin
        pending_q[r] <= '0;
      end
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  // Busy view of the counters; held at zero while in reset.
  always_comb begin
    busy_c = '0;
    for (int r = 1; r < int'(NUM_REGS); r++) begin
      busy_c[r] = !rst && (pending_q[r] != '0);
    end
  end

  assign sb.stall         = stall_c;
  assign sb.issue_accept  = accept_c;
  assign sb.busy_mask     = busy_c;
  assign sb.inflight_cnt  = inflight_q;
  assign sb.err_underflow = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed vector table plus randomized traffic
// checked against a counter-array reference model.
module tb_reg_scoreboard;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned PEND_W   = 2;
  localparam int          MAXP     = 3;
  localparam int          NVEC     = 20;
  localparam int          NRAND    = 1500;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_scoreboard_if #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .PEND_W(PEND_W)) sbif ();

  reg_scoreboard #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .PEND_W(PEND_W)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sbif)
  );

  typedef struct {
    logic        rst;
    logic        r1f;
    logic [4:0]  r1a;
    logic        r2f;
    logic [4:0]  r2a;
    logic        iv;
    logic        wen;
    logic [4:0]  rd;
    logic        fl;
    logic        wbf;
    logic [4:0]  wba;
    logic        e_stall;
    logic        e_acc;
    logic [31:0] e_busy;
    logic [6:0]  e_infl;
    logic        e_err;
  } vec_t;

  vec_t vecs[NVEC];
  int checks = 0;
  int errors = 0;

  // Reference model state.
  int pend[NUM_REGS];
  int infl;
  bit err;

  function automatic vec_t mk(input logic r, input logic r1f, input int r1a,
                              input logic r2f, input int r2a, input logic iv,
                              input logic wen, input int rd, input logic fl,
                              input logic wbf, input int wba, input logic st,
                              input logic ac, input logic [31:0] bm,
                              input int ifc, input logic er);
    vec_t v;
    v.rst = r; v.r1f = r1f; v.r1a = 5'(r1a); v.r2f = r2f; v.r2a = 5'(r2a);
    v.iv = iv; v.wen = wen; v.rd = 5'(rd); v.fl = fl; v.wbf = wbf; v.wba = 5'(wba);
    v.e_stall = st; v.e_acc = ac; v.e_busy = bm; v.e_infl = 7'(ifc); v.e_err = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rst                = v.rst;
    sbif.read1_flag    = v.r1f;
    sbif.read1_address = v.r1a;
    sbif.read2_flag    = v.r2f;
    sbif.read2_address = v.r2a;
    sbif.issue_valid   = v.iv;
    sbif.issue_wen     = v.wen;
    sbif.issue_rd      = v.rd;
    sbif.flush         = v.fl;
    sbif.wb_flag       = v.wbf;
    sbif.wb_address    = v.wba;
  endtask

  // Expected outputs for the current inputs, derived from the counter array.
  task automatic model_outputs(input vec_t v, output logic st, output logic ac,
                               output logic [31:0] bm);
    bit h1, h2, fu;
    h1 = v.r1f && v.r1a != 0 && pend[v.r1a] != 0 &&
         !(v.wbf && v.wba == v.r1a && pend[v.r1a] == 1);
    h2 = v.r2f && v.r2a != 0 && pend[v.r2a] != 0 &&
         !(v.wbf && v.wba == v.r2a && pend[v.r2a] == 1);
    fu = v.iv && v.wen && v.rd != 0 && pend[v.rd] == MAXP && !(v.wbf && v.wba == v.rd);
    st = !v.rst && v.iv && !v.fl && (h1 || h2 || fu);
    ac = !v.rst && v.iv && !v.fl && !st;
    bm = '0;
    for (int r = 1; r < 32; r++) bm[r] = !v.rst && pend[r] != 0;
  endtask

  task automatic model_update(input vec_t v, input logic ac);
    bit inc, dec;
    if (v.rst) begin
      for (int r = 0; r < 32; r++) pend[r] = 0;
      infl = 0;
      err  = 0;
    end else begin
      inc = ac && v.wen && v.rd != 0;
      dec = v.wbf && v.wba != 0;
      if (dec && pend[v.wba] == 0) err = 1;
      if (!(inc && dec && v.rd == v.wba)) begin
        if (inc) begin pend[v.rd]++; infl++; end
        if (dec && pend[v.wba] > 0) begin pend[v.wba]--; infl--; end
      end
    end
  endtask

  initial begin
    vec_t v;
    logic st, ac;
    logic [31:0] bm;
    int a;

    // Directed table: expectations are the values seen before that row's clock edge.
    vecs[0]  = mk(1, 1,5, 0,0, 1,1,5, 0, 0,0,  0,0, 32'h0,  0, 0);
    vecs[1]  = mk(0, 0,0, 0,0, 1,1,5, 0, 0,0,  0,1, 32'h0,  0, 0);
    vecs[2]  = mk(0, 1,5, 0,0, 1,0,0, 0, 0,0,  1,0, 32'h20, 1, 0);
    vecs[3]  = mk(0, 1,5, 0,0, 1,0,0, 0, 1,5,  0,1, 32'h20, 1, 0);
    vecs[4]  = mk(0, 0,0, 0,0, 0,0,0, 0, 0,0,  0,0, 32'h0,  0, 0);
    vecs[5]  = mk(0, 0,0, 0,0, 1,1,7, 0, 0,0,  0,1, 32'h0,  0, 0);
    vecs[6]  = mk(0, 0,0, 0,0, 1,1,7, 0, 0,0,  0,1, 32'h80, 1, 0);
    vecs[7]  = mk(0, 0,0, 0,0, 1,1,7, 0, 0,0,  0,1, 32'h80, 2, 0);
    vecs[8]  = mk(0, 0,0, 0,0, 1,1,7, 0, 0,0,  1,0, 32'h80, 3, 0);
    vecs[9]  = mk(0, 0,0, 0,0, 1,1,7, 0, 1,7,  0,1, 32'h80, 3, 0);
    vecs[10] = mk(0, 0,0, 0,0, 0,0,0, 0, 0,0,  0,0, 32'h80, 3, 0);
    vecs[11] = mk(0, 1,0, 0,0, 1,1,0, 0, 0,0,  0,1, 32'h80, 3, 0);
    vecs[12] = mk(0, 0,0, 0,0, 0,0,0, 0, 1,9,  0,0, 32'h80, 3, 0);
    vecs[13] = mk(0, 0,0, 0,0, 0,0,0, 0, 0,0,  0,0, 32'h80, 3, 1);
    vecs[14] = mk(0, 0,0, 0,0, 0,0,0, 0, 0,0,  0,0, 32'h80, 3, 1);
    vecs[15] = mk(0, 0,0, 0,0, 1,1,5, 0, 0,0,  0,1, 32'h80, 3, 1);
    vecs[16] = mk(0, 0,0, 1,5, 1,1,3, 1, 1,5,  0,0, 32'hA0, 4, 1);
    vecs[17] = mk(0, 0,0, 0,0, 0,0,0, 0, 0,0,  0,0, 32'h80, 3, 1);
    vecs[18] = mk(1, 1,7, 0,0, 1,1,7, 0, 0,0,  0,0, 32'h0,  3, 1);
    vecs[19] = mk(0, 0,0, 0,0, 0,0,0, 0, 0,0,  0,0, 32'h0,  0, 0);

    // One unchecked reset cycle so the first row sees reset state.
    apply(mk(1, 0,0, 0,0, 0,0,0, 0, 0,0, 0,0, 0, 0, 0));
    @(posedge clk); #1;

    for (int i = 0; i < NVEC; i++) begin
      apply(vecs[i]);
      @(negedge clk);
      chk($sformatf("vec%0d stall", i), 32'(sbif.stall), 32'(vecs[i].e_stall));
      chk($sformatf("vec%0d accept", i), 32'(sbif.issue_accept), 32'(vecs[i].e_acc));
      chk($sformatf("vec%0d busy", i), sbif.busy_mask, vecs[i].e_busy);
      chk($sformatf("vec%0d inflight", i), 32'(sbif.inflight_cnt), 32'(vecs[i].e_infl));
      chk($sformatf("vec%0d err", i), 32'(sbif.err_underflow), 32'(vecs[i].e_err));
      @(posedge clk); #1;
    end

    // Randomized traffic: start from reset, then mostly legal writebacks.
    for (int i = 0; i < NRAND; i++) begin
      v = mk(0, 0,0, 0,0, 0,0,0, 0, 0,0, 0,0, 0, 0, 0);
      v.rst = (i == 0) || ($urandom_range(0, 199) == 0);
      v.r1f = 1'($urandom_range(0, 1));
      v.r1a = 5'($urandom_range(0, 7));
      v.r2f = 1'($urandom_range(0, 1));
      v.r2a = 5'($urandom_range(0, 7));
      v.iv  = $urandom_range(0, 3) != 0;
      v.wen = $urandom_range(0, 3) != 0;
      v.rd  = 5'($urandom_range(0, 7));
      v.fl  = $urandom_range(0, 9) == 0;
      v.wbf = $urandom_range(0, 1) == 1;
      a = $urandom_range(0, 7);
      if ($urandom_range(0, 9) != 0) begin
        for (int k = 0; k < 8; k++) begin
          if (pend[(a + k) % 8] != 0) begin
            a = (a + k) % 8;
            break;
          end
        end
      end
      v.wba = 5'(a);
      apply(v);
      @(negedge clk);
      model_outputs(v, st, ac, bm);
      chk($sformatf("rnd%0d stall", i), 32'(sbif.stall), 32'(st));
      chk($sformatf("rnd%0d accept", i), 32'(sbif.issue_accept), 32'(ac));
      chk($sformatf("rnd%0d busy", i), sbif.busy_mask, bm);
      if (i > 0) begin
        chk($sformatf("rnd%0d inflight", i), 32'(sbif.inflight_cnt), 32'(infl));
        chk($sformatf("rnd%0d err", i), 32'(sbif.err_underflow), 32'(err));
      end
      model_update(v, ac);
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
